// File: rtl/grid_stream_loader.sv
// Serial ASCII grid loader: packs '@'/'.' rows into a DEPTH x WIDTH bit matrix.
// Define GRID_PAD_ROWS_EN to accept short rows and early blank-line termination.
module grid_stream_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [WIDTH-1:0]                    grid [DEPTH-1:0],
  output logic                                grid_valid,
  input  logic                                grid_ack,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]    paper_count,
  output logic                                err,
  input  logic                                err_restart
);

  localparam int CW  = $clog2(WIDTH+1);
  localparam int RW  = $clog2(DEPTH+1);
  localparam int PCW = $clog2(WIDTH*DEPTH+1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_FULL,
    S_ERR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_col, w_col_nxt;
  logic [RW-1:0]    r_row, w_row_nxt;
  logic [PCW-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_grid [DEPTH-1:0];

  logic w_accept;
  logic w_is_at, w_is_dot, w_is_lf, w_is_cr;
  logic w_col_full, w_col_zero, w_last_row;
  logic w_clear, w_wr_en, w_wr_val;

  assign in_ready   = (r_state != S_FULL);
  assign w_accept   = in_valid && in_ready;
  assign w_is_at    = (in_data == 8'h40);
  assign w_is_dot   = (in_data == 8'h2E);
  assign w_is_lf    = (in_data == 8'h0A);
  assign w_is_cr    = (in_data == 8'h0D);
  assign w_col_full = (r_col == CW'(WIDTH));
  assign w_col_zero = (r_col == '0);
  assign w_last_row = (r_row == RW'(DEPTH-1));

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_cnt_nxt   = r_cnt;
    w_clear     = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_val    = w_is_at;
    unique case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          unique case (1'b1)
            w_is_at, w_is_dot: begin
              if (w_col_full) begin
                w_state_nxt = S_ERR;
              end else begin
                w_wr_en   = 1'b1;
                w_col_nxt = r_col + CW'(1);
                if (w_is_at) w_cnt_nxt = r_cnt + PCW'(1);
              end
            end
            w_is_lf: begin
              if (w_col_full) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + RW'(1);
                if (w_last_row) w_state_nxt = S_FULL;
              end else if (w_col_zero) begin
`ifdef GRID_PAD_ROWS_EN
                // blank line after real rows ends the grid early
                if (r_row != '0) w_state_nxt = S_FULL;
`endif
              end else begin
`ifdef GRID_PAD_ROWS_EN
                w_col_nxt = '0;
                w_row_nxt = r_row + RW'(1);
                if (w_last_row) w_state_nxt = S_FULL;
`else
                w_state_nxt = S_ERR;
`endif
              end
            end
            w_is_cr: begin
            end
            default: w_state_nxt = S_ERR;
          endcase
        end
      end
      S_FULL: begin
        if (grid_ack) begin
          w_clear     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_ERR: begin
        // restart wins over any byte drained on the same edge
        if (err_restart) begin
          w_clear     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
    if (w_clear) begin
      w_col_nxt = '0;
      w_row_nxt = '0;
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_LOAD;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) r_grid[r] <= '0;
    end else if (w_clear) begin
      for (int r = 0; r < DEPTH; r++) r_grid[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (w_wr_en && r_row == RW'(r) && r_col == CW'(c))
            r_grid[r][c] <= w_wr_val;
        end
      end
    end
  end

  assign grid        = r_grid;
  assign paper_count = r_cnt;
  assign grid_valid  = (r_state == S_FULL);
  assign err         = (r_state == S_ERR);

endmodule

// File: tb/tb_grid_stream_loader.sv
// Directed bench for grid_stream_loader: 4x3 instance plus a default 16x16.
// Expected grids are hand-packed with bit j = character j of a line.
module tb_grid_stream_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] d4 = 8'h0;
  logic       v4 = 1'b0;
  logic       rdy4;
  logic [3:0] g4 [2:0];
  logic       gv4;
  logic       ack4 = 1'b0;
  logic [3:0] pc4;
  logic       err4;
  logic       rs4 = 1'b0;

  logic [7:0]  d16 = 8'h0;
  logic        v16 = 1'b0;
  logic        rdy16;
  logic [15:0] g16 [15:0];
  logic        gv16;
  logic        ack16 = 1'b0;
  logic [8:0]  pc16;
  logic        err16;
  logic        rs16 = 1'b0;

  int checks = 0;
  int errors = 0;

  grid_stream_loader #(.WIDTH(4), .DEPTH(3)) u4 (
    .clk(clk), .reset_n(rst_n), .in_data(d4), .in_valid(v4),
    .in_ready(rdy4), .grid(g4), .grid_valid(gv4), .grid_ack(ack4),
    .paper_count(pc4), .err(err4), .err_restart(rs4)
  );

  grid_stream_loader u16 (
    .clk(clk), .reset_n(rst_n), .in_data(d16), .in_valid(v16),
    .in_ready(rdy16), .grid(g16), .grid_valid(gv16), .grid_ack(ack16),
    .paper_count(pc16), .err(err16), .err_restart(rs16)
  );

  task automatic send4(input byte b);
    d4 = b;
    v4 = 1'b1;
    @(posedge clk);
    #1;
    v4 = 1'b0;
  endtask

  task automatic send_str4(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) begin
      send4(s[i]);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_ack4();
    ack4 = 1'b1;
    @(posedge clk);
    #1;
    ack4 = 1'b0;
  endtask

  task automatic pulse_rs4();
    rs4 = 1'b1;
    @(posedge clk);
    #1;
    rs4 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL rst_gv got %0h exp 0", gv4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", err4); end
    checks++; if (pc4 !== 4'd0) begin errors++; $display("FAIL rst_pc got %0h exp 0", pc4); end
    checks++; if (g4[0] !== 4'h0) begin errors++; $display("FAIL rst_g0 got %0h exp 0", g4[0]); end
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL rst_rdy got %0h exp 1", rdy4); end
  endtask

  task automatic test_basic();
    send_str4("@@.@\n.@@.\n@..@", 1'b0);
    d4 = 8'h0A;
    v4 = 1'b1;
    #1;
    checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL basic_gv_early got %0h exp 0", gv4); end
    @(posedge clk);
    #1;
    v4 = 1'b0;
    checks++; if (gv4 !== 1'b1) begin errors++; $display("FAIL basic_gv got %0h exp 1", gv4); end
    checks++; if (g4[0] !== 4'b1011) begin errors++; $display("FAIL basic_g0 got %0h exp b", g4[0]); end
    checks++; if (g4[1] !== 4'b0110) begin errors++; $display("FAIL basic_g1 got %0h exp 6", g4[1]); end
    checks++; if (g4[2] !== 4'b1001) begin errors++; $display("FAIL basic_g2 got %0h exp 9", g4[2]); end
    checks++; if (pc4 !== 4'd7) begin errors++; $display("FAIL basic_pc got %0d exp 7", pc4); end
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL basic_rdy got %0h exp 0", rdy4); end
    d4 = 8'h2E;
    v4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v4 = 1'b0;
    checks++; if (g4[0] !== 4'b1011) begin errors++; $display("FAIL hold_g0 got %0h exp b", g4[0]); end
    checks++; if (pc4 !== 4'd7) begin errors++; $display("FAIL hold_pc got %0d exp 7", pc4); end
    checks++; if (gv4 !== 1'b1) begin errors++; $display("FAIL hold_gv got %0h exp 1", gv4); end
    pulse_ack4();
  endtask

  task automatic test_toggle_cr();
    send_str4("@@.@\015\n.@@.\015\n@..@\015\n", 1'b1);
    checks++; if (gv4 !== 1'b1) begin errors++; $display("FAIL tog_gv got %0h exp 1", gv4); end
    checks++; if (g4[0] !== 4'b1011) begin errors++; $display("FAIL tog_g0 got %0h exp b", g4[0]); end
    checks++; if (g4[1] !== 4'b0110) begin errors++; $display("FAIL tog_g1 got %0h exp 6", g4[1]); end
    checks++; if (g4[2] !== 4'b1001) begin errors++; $display("FAIL tog_g2 got %0h exp 9", g4[2]); end
    checks++; if (pc4 !== 4'd7) begin errors++; $display("FAIL tog_pc got %0d exp 7", pc4); end
    pulse_ack4();
    checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL ack_gv got %0h exp 0", gv4); end
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL ack_rdy got %0h exp 1", rdy4); end
    checks++; if (pc4 !== 4'd0) begin errors++; $display("FAIL ack_pc got %0d exp 0", pc4); end
    for (int r = 0; r < 3; r++) begin
      checks++; if (g4[r] !== 4'h0) begin errors++; $display("FAIL ack_g%0d got %0h exp 0", r, g4[r]); end
    end
  endtask

  task automatic test_overflow();
    send_str4("@@@@", 1'b0);
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL ovf_err_early got %0h exp 0", err4); end
    send4("@");
    checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL ovf_err got %0h exp 1", err4); end
    checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL ovf_gv got %0h exp 0", gv4); end
    send_str4("@\n..", 1'b0);
    checks++; if (rdy4 !== 1'b1) begin errors++; $display("FAIL ovf_rdy got %0h exp 1", rdy4); end
    checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0h exp 1", err4); end
    pulse_rs4();
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL rs_err got %0h exp 0", err4); end
    checks++; if (pc4 !== 4'd0) begin errors++; $display("FAIL rs_pc got %0d exp 0", pc4); end
    checks++; if (g4[0] !== 4'h0) begin errors++; $display("FAIL rs_g0 got %0h exp 0", g4[0]); end
    send_str4("....\n@@@@\n.@..\n", 1'b0);
    checks++; if (gv4 !== 1'b1) begin errors++; $display("FAIL rs_gv got %0h exp 1", gv4); end
    checks++; if (g4[0] !== 4'b0000) begin errors++; $display("FAIL rs_l0 got %0h exp 0", g4[0]); end
    checks++; if (g4[1] !== 4'b1111) begin errors++; $display("FAIL rs_l1 got %0h exp f", g4[1]); end
    checks++; if (g4[2] !== 4'b0010) begin errors++; $display("FAIL rs_l2 got %0h exp 2", g4[2]); end
    checks++; if (pc4 !== 4'd5) begin errors++; $display("FAIL rs_lpc got %0d exp 5", pc4); end
    pulse_ack4();
  endtask

  task automatic test_bad_char();
    send_str4("@x", 1'b0);
    checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL bad_err got %0h exp 1", err4); end
    pulse_rs4();
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL bad_rs got %0h exp 0", err4); end
  endtask

  task automatic test_short_row();
    send_str4("@@\n", 1'b0);
`ifdef GRID_PAD_ROWS_EN
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL pad_err got %0h exp 0", err4); end
    checks++; if (g4[0] !== 4'b0011) begin errors++; $display("FAIL pad_g0 got %0h exp 3", g4[0]); end
    send_str4("@@@@\n\n", 1'b0);
    checks++; if (gv4 !== 1'b1) begin errors++; $display("FAIL pad_gv got %0h exp 1", gv4); end
    checks++; if (g4[1] !== 4'b1111) begin errors++; $display("FAIL pad_g1 got %0h exp f", g4[1]); end
    checks++; if (g4[2] !== 4'b0000) begin errors++; $display("FAIL pad_g2 got %0h exp 0", g4[2]); end
    checks++; if (pc4 !== 4'd6) begin errors++; $display("FAIL pad_pc got %0d exp 6", pc4); end
    pulse_ack4();
`else
    checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL short_err got %0h exp 1", err4); end
    checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL short_gv got %0h exp 0", gv4); end
    pulse_rs4();
`endif
  endtask

  task automatic test_async_reset();
    send_str4("@@.@\n@.", 1'b0);
    checks++; if (g4[0] !== 4'b1011) begin errors++; $display("FAIL ar_pre_g0 got %0h exp b", g4[0]); end
    checks++; if (pc4 !== 4'd4) begin errors++; $display("FAIL ar_pre_pc got %0d exp 4", pc4); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc4 !== 4'd0) begin errors++; $display("FAIL ar_pc got %0d exp 0", pc4); end
    checks++; if (g4[0] !== 4'h0) begin errors++; $display("FAIL ar_g0 got %0h exp 0", g4[0]); end
    checks++; if (g4[1] !== 4'h0) begin errors++; $display("FAIL ar_g1 got %0h exp 0", g4[1]); end
    checks++; if (gv4 !== 1'b0) begin errors++; $display("FAIL ar_gv got %0h exp 0", gv4); end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_str4("\n@.@.\n.@.@\n@@@@\n", 1'b0);
    checks++; if (gv4 !== 1'b1) begin errors++; $display("FAIL ar_gv2 got %0h exp 1", gv4); end
    checks++; if (g4[0] !== 4'b0101) begin errors++; $display("FAIL ar_l0 got %0h exp 5", g4[0]); end
    checks++; if (g4[1] !== 4'b1010) begin errors++; $display("FAIL ar_l1 got %0h exp a", g4[1]); end
    checks++; if (g4[2] !== 4'b1111) begin errors++; $display("FAIL ar_l2 got %0h exp f", g4[2]); end
    checks++; if (pc4 !== 4'd8) begin errors++; $display("FAIL ar_lpc got %0d exp 8", pc4); end
    pulse_ack4();
  endtask

  task automatic test_full16();
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c <= 16; c++) begin
        d16 = (c == 16) ? 8'h0A : 8'h40;
        v16 = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    v16 = 1'b0;
    checks++; if (gv16 !== 1'b1) begin errors++; $display("FAIL f16_gv got %0h exp 1", gv16); end
    checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL f16_err got %0h exp 0", err16); end
    checks++; if (rdy16 !== 1'b0) begin errors++; $display("FAIL f16_rdy got %0h exp 0", rdy16); end
    checks++; if (pc16 !== 9'd256) begin errors++; $display("FAIL f16_pc got %0d exp 256", pc16); end
    for (int r = 0; r < 16; r++) begin
      checks++; if (g16[r] !== 16'hFFFF) begin errors++; $display("FAIL f16_g%0d got %0h exp ffff", r, g16[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_cr();
    test_overflow();
    test_bad_char();
    test_short_row();
    test_async_reset();
    test_full16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_stream_loader.md
Name: grid_stream_loader

Overview:
- Upstream stage of the paper-removal engine.
- Accepts the puzzle grid as a serial ASCII byte stream over a valid/ready handshake: '@' means paper (1), '.' means empty (0), LF ends a row.
- Packs the stream into a DEPTH x WIDTH bit matrix and presents it, with a paper count, to the iterative removal block.
- Holds the grid stable until the consumer acknowledges it, then re-arms for the next grid.

Parameters:
- WIDTH, 16, columns per row (bits per grid word).
- DEPTH, 16, number of rows.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  ASCII byte.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- grid  output  WIDTH x DEPTH (unpacked array [WIDTH-1:0] grid [DEPTH-1:0])  packed grid; row i = line i; bit j = character j of that line.
- grid_valid  output  1  complete grid present; feeds the removal block's load.
- grid_ack  input  1  single-cycle pulse from consumer: grid taken.
- paper_count  output  $clog2(WIDTH*DEPTH+1)  number of '@' in the loaded grid.
- err  output  1  sticky format error.
- err_restart  input  1  synchronous pulse that clears the error and re-arms.

Behaviour:
- Clock and reset:
  - Single clock domain clk. reset_n is asynchronous, active-low.
  - While reset_n is low: state=LOAD, row=0, col=0, all grid rows=0, paper_count=0, grid_valid=0, err=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-load discards the partial grid.
- Handshake: a byte transfers on a clock edge with in_valid && in_ready. in_ready is combinational from state only and never depends on in_valid.
- State LOAD (in_ready=1). Per accepted byte:
  - 0x40 '@': grid[row][col]<=1, paper_count+=1, col+=1.
  - 0x2E '.': grid[row][col]<=0, col+=1.
  - '@' or '.' with col==WIDTH: row overflow, go to ERR; the grid bit is not written.
  - 0x0A LF with col==WIDTH: col<=0, row+=1. If row was DEPTH-1, go to FULL.
  - 0x0A LF with col==0: blank line, ignored (no row advance).
  - 0x0A LF with 0<col<WIDTH: short row, go to ERR.
  - 0x0D CR: ignored.
  - Any other byte: go to ERR.
- State FULL:
  - grid_valid=1, in_ready=0. grid and paper_count are held constant.
  - grid_valid rises the cycle after the final LF is accepted (1-cycle latency).
  - On grid_ack: grid cleared to 0, paper_count=0, row=col=0, next state LOAD (grid_valid=0 the next cycle).
  - grid_ack outside FULL is ignored.
- State ERR:
  - err=1, grid_valid=0, in_ready=1; bytes are drained and discarded.
  - On err_restart: same clear as an ack, err=0, next state LOAD.
  - err_restart in LOAD or FULL is ignored.
- Simultaneous events: in ERR, err_restart together with an accepted byte means the byte is discarded and the restart wins.
- Width rules:
  - col is $clog2(WIDTH+1) bits and row is $clog2(DEPTH+1) bits; neither ever exceeds WIDTH or DEPTH.
  - paper_count cannot overflow by construction.
- Implementation scope: 3-state FSM, per-bit write decode, counters; roughly 150-250 lines.

Optional Feature:
- Macro GRID_PAD_ROWS_EN.
- When defined:
  - LF with 0<col<WIDTH is legal; the remaining bits of that row stay 0 (already cleared) and the row advances normally.
  - LF with col==0 and row>0 finishes the grid early: remaining rows are 0 and the block goes to FULL on that edge.
- When undefined: short rows go to ERR and blank lines are ignored, as in Behaviour.

Test Plan (WIDTH=4, DEPTH=3 unless noted):
- Reset then stream "@@.@\n.@@.\n@..@\n" with in_valid=1 each cycle:
  - grid_valid=1 one cycle after the last LF.
  - grid[0]=4'b1011, grid[1]=4'b0110, grid[2]=4'b1001, paper_count=7.
  - in_ready=0 while FULL.
- Same stream with in_valid toggling 1/0 and CR inserted before each LF: identical result. Then pulse grid_ack: grid_valid=0, grid all 0, in_ready=1 next cycle.
- Stream "@@@@@": err=1 after the 5th byte, grid_valid stays 0, further bytes accepted and dropped. err_restart: err=0, row=col=0.
- Stream "@x": err=1. Stream "@@\n" without the macro: err=1. With GRID_PAD_ROWS_EN: grid[0]=4'b0011 and no error.
- Assert reset_n low asynchronously mid-row 1, between clock edges: outputs clear immediately, not on the next edge. After release, a full valid grid loads correctly.
- Defaults 16x16, all '@': paper_count=256 (9-bit), every grid row=16'hFFFF.
